// File: rtl/stage_4.sv
// MIPS execute stage: ALU, branch target, dest select, 32-cycle shift-add multiply, EX/MEM register.
// Latency 1 cycle (multiply 33); busy stalls upstream while a multiply is in progress; flush inserts a bubble.
module stage_4 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PC,
   input  logic        reg_dest,
   input  logic        alu_src,
   input  logic        mem_to_reg,
   input  logic        reg_write,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        branch,
   input  logic        alu0,
   input  logic        alu1,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imidiate,
   input  logic [5:0]  funct_code,
   input  logic [31:0] data_out1,
   input  logic [31:0] data_out2,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] new_PC,
   output logic [31:0] new_alu_result,
   output logic        new_zero,
   output logic [31:0] new_write_data,
   output logic [4:0]  new_rd,
   output logic        new_mem_to_reg,
   output logic        new_reg_write,
   output logic        new_mem_read,
   output logic        new_mem_write,
   output logic        new_branch
);

   localparam logic [5:0] F_MULT = 6'h18;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;

   typedef enum logic {IDLE, MUL} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;

   logic [31:0] pc_q, res_q, wd_q;
   logic        zero_q;
   logic [4:0]  rd_q;
   logic        m2r_q, rw_q, mr_q, mw_q, br_q;

   logic [31:0] imm_ext, op_a, op_b, alu_res, mul_final, result;
   logic        is_mult, bubble;

   assign imm_ext = {{16{imidiate[15]}}, imidiate};
   assign op_a    = data_out1;
   assign op_b    = alu_src ? imm_ext : data_out2;
   assign is_mult = alu1 && !alu0 && (funct_code == F_MULT);

   always_comb begin
      alu_res = '0;
      case ({alu1, alu0})
         2'b01: alu_res = op_a - op_b;
         2'b10: begin
            case (funct_code)
               F_ADD:   alu_res = op_a + op_b;
               F_SUB:   alu_res = op_a - op_b;
               F_AND:   alu_res = op_a & op_b;
               F_OR:    alu_res = op_a | op_b;
               F_NOR:   alu_res = ~(op_a | op_b);
               F_SLT:   alu_res = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
               default: alu_res = '0;
            endcase
         end
         default: alu_res = op_a + op_b;
      endcase
   end

   // Last partial product is folded in combinationally so the result lands on the 33rd edge.
   assign mul_final = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
   assign result    = (state_q == MUL) ? mul_final : alu_res;

   assign busy   = !flush && (((state_q == IDLE) && is_mult) ||
                              ((state_q == MUL) && (cnt_q != 5'd31)));
   assign bubble = flush || busy;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (is_mult) begin
                  state_d  = MUL;
                  mcand_d  = op_a;
                  mplier_d = op_b;
                  acc_d    = '0;
                  cnt_d    = '0;
               end
            end
            MUL: begin
               acc_d    = mul_final;
               mcand_d  = {mcand_q[30:0], 1'b0};
               mplier_d = {1'b0, mplier_q[31:1]};
               cnt_d    = cnt_q + 5'd1;
               if (cnt_q == 5'd31) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   // EX/MEM register: a bubble clears control only; data fields hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= '0;
         res_q  <= '0;
         wd_q   <= '0;
         zero_q <= 1'b0;
         rd_q   <= '0;
         m2r_q  <= 1'b0;
         rw_q   <= 1'b0;
         mr_q   <= 1'b0;
         mw_q   <= 1'b0;
         br_q   <= 1'b0;
      end else if (bubble) begin
         m2r_q <= 1'b0;
         rw_q  <= 1'b0;
         mr_q  <= 1'b0;
         mw_q  <= 1'b0;
         br_q  <= 1'b0;
      end else begin
         pc_q   <= PC + {imm_ext[29:0], 2'b00};
         res_q  <= result;
         wd_q   <= data_out2;
         zero_q <= (result == 32'd0);
         rd_q   <= reg_dest ? rd : rt;
         m2r_q  <= mem_to_reg;
         rw_q   <= reg_write;
         mr_q   <= mem_read;
         mw_q   <= mem_write;
         br_q   <= branch;
      end
   end

   assign new_PC         = pc_q;
   assign new_alu_result = res_q;
   assign new_zero       = zero_q;
   assign new_write_data = wd_q;
   assign new_rd         = rd_q;
   assign new_mem_to_reg = m2r_q;
   assign new_reg_write  = rw_q;
   assign new_mem_read   = mr_q;
   assign new_mem_write  = mw_q;
   assign new_branch     = br_q;

endmodule

// File: tb/tb_stage_4.sv
// Scoreboarded random + directed bench for the execute stage.
module tb_stage_4;

   typedef struct packed {
      logic [31:0] pc, a, b;
      logic [15:0] imm;
      logic [5:0]  funct;
      logic [4:0]  rt, rd;
      logic        reg_dest, alu_src, m2r, rw, mr, mw, br, alu0, alu1;
   } stim_t;

   typedef struct packed {
      logic        bubble;
      logic [31:0] pc, res, wd;
      logic        zero;
      logic [4:0]  rd;
      logic [4:0]  ctl;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PC, data_out1, data_out2;
   logic        reg_dest, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu0, alu1;
   logic [4:0]  rt, rd;
   logic [15:0] imidiate;
   logic [5:0]  funct_code;
   logic        flush;
   logic        busy;
   logic [31:0] new_PC, new_alu_result, new_write_data;
   logic        new_zero;
   logic [4:0]  new_rd;
   logic        new_mem_to_reg, new_reg_write, new_mem_read, new_mem_write, new_branch;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   stage_4 dut (
      .clk(clk), .rst_n(rst_n), .PC(PC),
      .reg_dest(reg_dest), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .branch(branch), .alu0(alu0), .alu1(alu1), .rt(rt), .rd(rd),
      .imidiate(imidiate), .funct_code(funct_code),
      .data_out1(data_out1), .data_out2(data_out2), .flush(flush),
      .busy(busy), .new_PC(new_PC), .new_alu_result(new_alu_result),
      .new_zero(new_zero), .new_write_data(new_write_data), .new_rd(new_rd),
      .new_mem_to_reg(new_mem_to_reg), .new_reg_write(new_reg_write),
      .new_mem_read(new_mem_read), .new_mem_write(new_mem_write),
      .new_branch(new_branch)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] dut_ctl();
      return {new_mem_to_reg, new_reg_write, new_mem_read, new_mem_write, new_branch};
   endfunction

   // Reference: instruction semantics in plain arithmetic.
   function automatic exp_t model(input stim_t s);
      exp_t        e;
      logic [31:0] imm, b;
      logic [63:0] p;
      imm = {{16{s.imm[15]}}, s.imm};
      b   = s.alu_src ? imm : s.b;
      p   = {32'd0, s.a} * {32'd0, b};
      case ({s.alu1, s.alu0})
         2'b01: e.res = s.a - b;
         2'b10: begin
            case (s.funct)
               6'h20:   e.res = s.a + b;
               6'h22:   e.res = s.a - b;
               6'h24:   e.res = s.a & b;
               6'h25:   e.res = s.a | b;
               6'h27:   e.res = ~(s.a | b);
               6'h2A:   e.res = ($signed(s.a) < $signed(b)) ? 32'd1 : 32'd0;
               6'h18:   e.res = p[31:0];
               default: e.res = 32'd0;
            endcase
         end
         default: e.res = s.a + b;
      endcase
      e.bubble = 1'b0;
      e.pc     = s.pc + imm * 32'd4;
      e.wd     = s.b;
      e.zero   = (e.res == 32'd0);
      e.rd     = s.reg_dest ? s.rd : s.rt;
      e.ctl    = {s.m2r, s.rw, s.mr, s.mw, s.br};
      return e;
   endfunction

   task automatic drive(input stim_t s);
      PC = s.pc; data_out1 = s.a; data_out2 = s.b; imidiate = s.imm;
      funct_code = s.funct; rt = s.rt; rd = s.rd; reg_dest = s.reg_dest;
      alu_src = s.alu_src; mem_to_reg = s.m2r; reg_write = s.rw;
      mem_read = s.mr; mem_write = s.mw; branch = s.br; alu0 = s.alu0; alu1 = s.alu1;
   endtask

   task automatic apply(input stim_t s, input bit fl, input bit exp_busy, input bit bub);
      exp_t e;
      @(negedge clk);
      drive(s);
      flush = fl;
      #1 chk("busy", 32'(busy), 32'(exp_busy));
      e = model(s);
      if (bub) begin
         e.bubble = 1'b1;
         e.ctl    = '0;
      end
      sb_q.push_back(e);
   endtask

   task automatic run_op(input stim_t s, input bit fl);
      bit is_m;
      is_m = s.alu1 && !s.alu0 && (s.funct == 6'h18);
      if (fl || !is_m) begin
         apply(s, fl, 1'b0, fl);
      end else begin
         for (int i = 0; i < 32; i++) apply(s, 1'b0, 1'b1, 1'b1);
         apply(s, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   function automatic stim_t rtype(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
      stim_t s;
      s = '0;
      s.a = a; s.b = b; s.funct = f; s.alu1 = 1'b1; s.rw = 1'b1;
      s.reg_dest = 1'b1; s.rd = 5'd3; s.rt = 5'd4; s.pc = 32'h100;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t     s;
      logic [5:0] fl [7];
      fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
      s = stim_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      s.funct = fl[$urandom_range(6)];
      if ($urandom_range(5) == 0) begin
         s.alu1 = 1'b1; s.alu0 = 1'b0; s.funct = 6'h18;
      end
      if ($urandom_range(3) == 0) s.a = 32'(s.b);
      return s;
   endfunction

   // Monitor: every registered EX/MEM update is compared with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ctl", 32'(dut_ctl()), 32'(e.ctl));
            if (!e.bubble) begin
               chk("result", new_alu_result, e.res);
               chk("zero", 32'(new_zero), 32'(e.zero));
               chk("pc", new_PC, e.pc);
               chk("wdata", new_write_data, e.wd);
               chk("rd", 32'(new_rd), 32'(e.rd));
            end
         end
      end
   end

   initial begin
      stim_t s, m;
      rst_n = 1'b0;
      flush = 1'b0;
      drive('0);
      #1;
      chk("rst_result", new_alu_result, 32'd0);
      chk("rst_pc", new_PC, 32'd0);
      chk("rst_ctl", 32'(dut_ctl()), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      s = rtype(32'd5, 32'd3, 6'h20);
      run_op(s, 1'b0); settle();
      chk("add_res", new_alu_result, 32'd8);
      chk("add_zero", 32'(new_zero), 32'd0);
      chk("add_rw", 32'(new_reg_write), 32'd1);

      s = '0; s.a = 32'h100; s.imm = 16'hFFFC; s.alu_src = 1'b1;
      s.mr = 1'b1; s.m2r = 1'b1; s.rw = 1'b1; s.rt = 5'd9; s.rd = 5'd17;
      run_op(s, 1'b0); settle();
      chk("lw_res", new_alu_result, 32'h0FC);
      chk("lw_mr", 32'(new_mem_read), 32'd1);
      chk("lw_rd", 32'(new_rd), 32'd9);

      s = '0; s.alu0 = 1'b1; s.a = 32'h1234; s.b = 32'h1234; s.pc = 32'h40;
      s.imm = 16'h0003; s.br = 1'b1;
      run_op(s, 1'b0); settle();
      chk("beq_zero", 32'(new_zero), 32'd1);
      chk("beq_pc", new_PC, 32'h4C);
      chk("beq_br", 32'(new_branch), 32'd1);

      run_op(rtype(32'hFFFF_FFFF, 32'd1, 6'h2A), 1'b0); settle();
      chk("slt_neg", new_alu_result, 32'd1);
      run_op(rtype(32'd1, 32'hFFFF_FFFF, 6'h2A), 1'b0); settle();
      chk("slt_pos", new_alu_result, 32'd0);

      run_op(rtype(32'd7, 32'd6, 6'h18), 1'b0); settle();
      chk("mul_42", new_alu_result, 32'd42);
      chk("mul_rw", 32'(new_reg_write), 32'd1);
      run_op(rtype(32'hFFFF_FFFF, 32'd2, 6'h18), 1'b0);
      run_op(rtype(32'h0001_0003, 32'h0002_0005, 6'h18), 1'b0); settle();
      chk("mul_b2b", new_alu_result, 32'h000B_000F);

      m = rtype(32'd9, 32'd9, 6'h18);
      for (int i = 0; i < 10; i++) apply(m, 1'b0, 1'b1, 1'b1);
      apply(m, 1'b1, 1'b0, 1'b1); settle();
      chk("flush_rw", 32'(new_reg_write), 32'd0);
      run_op(rtype(32'd20, 32'd22, 6'h20), 1'b0); settle();
      chk("post_flush_add", new_alu_result, 32'd42);

      for (int i = 0; i < 5; i++) apply(m, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_result", new_alu_result, 32'd0);
      chk("arst_pc", new_PC, 32'd0);
      chk("arst_wd", new_write_data, 32'd0);
      chk("arst_ctl", 32'(dut_ctl()), 32'd0);
      drive('0);
      flush = 1'b0;
      #1 chk("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(rtype(32'd5, 32'd3, 6'h20), 1'b0); settle();
      chk("arst_add", new_alu_result, 32'd8);

      for (int i = 0; i < 300; i++) begin
         s = rand_stim();
         run_op(s, ($urandom_range(7) == 0));
      end
      settle();
      settle();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
